// File: rtl/btn_pkg.sv
// btn_pkg: shared types, widths and helpers for btn_event_ctrl
package btn_pkg;
  localparam int CW = 4;
  typedef enum logic [1:0] {LOW, WAIT_HI, HIGH, WAIT_LO} st_e;
  typedef enum logic [1:0] {PRESS = 2'b00, RELEASE = 2'b01, LONG = 2'b10} ev_type_e;
  function automatic int wrap(input int a, input int n);
    return a >= n ? a - n : a;
  endfunction
endpackage

// File: rtl/btn_event_ctrl_if.sv
// btn_event_ctrl_if: event handshake bundle between btn_event_ctrl and its consumer
interface btn_event_ctrl_if #(parameter int N_SW = 4);
  import btn_pkg::*;
  localparam int IW = $clog2(N_SW);
  logic ev_valid;
  logic ev_ready;
  logic ev_drop;
  logic [IW-1:0] ev_id;
  ev_type_e ev_type;
  modport master(output ev_valid, ev_id, ev_type, ev_drop, input ev_ready);
  modport slave(input ev_valid, ev_id, ev_type, ev_drop, output ev_ready);
endinterface

// File: rtl/btn_db_ch.sv
// btn_db_ch: one switch channel -- 2-flop synchronizer, tick-based debounce FSM and
// (with BTN_LONG_PRESS_EN defined) a saturating long-press counter
module btn_db_ch import btn_pkg::*; #(
`ifdef BTN_LONG_PRESS_EN
  parameter int LONG_TICKS = 200,
`endif
  parameter int DB_TICKS = 10
) (
  input logic clk,
  input logic rst,
  input logic sw,
  input logic tick,
  output logic db,
  output logic evt,
  output ev_type_e etype
);
  logic s1, s2, done;
  st_e st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      st <= LOW;
      cnt <= '0;
    end else begin
      s1 <= sw;
      s2 <= s1;
      st <= st_n;
      cnt <= cnt_n;
    end
  end
  assign done = tick && cnt == CW'(DB_TICKS - 1);
  assign db = st == HIGH || st == WAIT_LO;
`ifdef BTN_LONG_PRESS_EN
  logic [7:0] lc;
  logic lfire;
  assign lfire = st == HIGH && s2 && tick && lc == 8'(LONG_TICKS - 1);
  always_ff @(posedge clk) begin
    if (rst || st_n != HIGH) lc <= '0;
    else if (st == HIGH && tick && lc != 8'(LONG_TICKS)) lc <= lc + 8'd1;
  end
`endif
  always_comb begin
    st_n = st;
    cnt_n = cnt;
    evt = 1'b0;
    etype = PRESS;
    unique case (st)
      LOW: if (s2) begin
        st_n = WAIT_HI;
        cnt_n = '0;
      end
      WAIT_HI: if (!s2) st_n = LOW;
        else if (done) begin
          st_n = HIGH;
          evt = 1'b1;
        end else if (tick) cnt_n = cnt + CW'(1);
      HIGH: if (!s2) begin
        st_n = WAIT_LO;
        cnt_n = '0;
      end
      WAIT_LO: if (s2) st_n = HIGH;
        else if (done) begin
          st_n = LOW;
          evt = 1'b1;
          etype = RELEASE;
        end else if (tick) cnt_n = cnt + CW'(1);
    endcase
`ifdef BTN_LONG_PRESS_EN
    if (lfire) begin
      evt = 1'b1;
      etype = LONG;
    end
`endif
  end
endmodule

// File: rtl/btn_event_ctrl.sv
// btn_event_ctrl: N_SW debounced switches with per-channel event slots, round-robin
// arbitration and a valid/ready event port; BTN_LONG_PRESS_EN adds long-press events
module btn_event_ctrl import btn_pkg::*; #(
  parameter int N_SW = 4,
  parameter int TICK_DIV = 50000,
  parameter int DB_TICKS = 10,
  parameter int LONG_TICKS = 200
) (
  input logic clk,
  input logic rst,
  input logic [N_SW-1:0] sw,
  output logic [N_SW-1:0] db,
  btn_event_ctrl_if.master ev
);
  localparam int IW = $clog2(N_SW);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  if (DB_TICKS < 1 || DB_TICKS > 15 || LONG_TICKS < 1 || LONG_TICKS > 255) begin : g_bad_cfg
    $error("btn_event_ctrl: DB_TICKS or LONG_TICKS out of range");
  end
  logic [PW-1:0] pcnt;
  logic tick, gv, gnt;
  logic [N_SW-1:0] evt, pend, clr, drop;
  ev_type_e et [N_SW];
  ev_type_e pty [N_SW];
  logic [IW-1:0] rr, gi;
  assign tick = pcnt == PW'(TICK_DIV - 1);
  always_ff @(posedge clk) pcnt <= (rst || tick) ? '0 : pcnt + PW'(1);
  for (genvar i = 0; i < N_SW; i++) begin : g_ch
    btn_db_ch #(
`ifdef BTN_LONG_PRESS_EN
      .LONG_TICKS(LONG_TICKS),
`endif
      .DB_TICKS(DB_TICKS)
    ) u_ch (
      .clk(clk),
      .rst(rst),
      .sw(sw[i]),
      .tick(tick),
      .db(db[i]),
      .evt(evt[i]),
      .etype(et[i])
    );
  end
  // Scan downwards so the channel closest after rr wins the last assignment.
  always_comb begin
    gv = 1'b0;
    gi = rr;
    for (int k = N_SW - 1; k >= 0; k--)
      if (pend[IW'(wrap(int'(rr) + k, N_SW))]) begin
        gv = 1'b1;
        gi = IW'(wrap(int'(rr) + k, N_SW));
      end
  end
  assign gnt = gv && !ev.ev_valid;
  always_comb begin
    clr = '0;
    clr[gi] = gnt;
  end
  // A slot freed by this cycle's grant can take a new event without a drop.
  assign drop = evt & pend & ~clr;
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
      rr <= '0;
      ev.ev_valid <= 1'b0;
      ev.ev_id <= '0;
      ev.ev_type <= PRESS;
      ev.ev_drop <= 1'b0;
      for (int i = 0; i < N_SW; i++) pty[i] <= PRESS;
    end else begin
      pend <= evt | (pend & ~clr);
      ev.ev_drop <= |drop;
      for (int i = 0; i < N_SW; i++) if (evt[i] && !drop[i]) pty[i] <= et[i];
      if (ev.ev_valid && ev.ev_ready) ev.ev_valid <= 1'b0;
      else if (gnt) begin
        ev.ev_valid <= 1'b1;
        ev.ev_id <= gi;
        ev.ev_type <= pty[gi];
        rr <= gi == IW'(N_SW - 1) ? '0 : gi + IW'(1);
      end
    end
  end
endmodule

// File: doc/btn_event_ctrl.md
BTN_EVENT_CTRL -- requirements
Module: btn_event_ctrl

Interface
REQ-001 SHALL have parameters, one per line:
- N_SW, 4, number of switch channels (2..8).
- TICK_DIV, 50000, clk cycles per shared sample tick.
- DB_TICKS, 10, consecutive stable ticks to accept a level (1..15, 4-bit counter).
- LONG_TICKS, 200, held-high ticks for a long-press event (8-bit).
REQ-002 SHALL have ports, one per line:
- clk, input, 1, single clock.
- rst, input, 1, reset; synchronous, active-high.
- sw, input, N_SW, raw asynchronous switch levels.
- db, output, N_SW, debounced levels.
- ev_valid, output, 1, event available.
- ev_ready, input, 1, consumer accepts event.
- ev_id, output, clog2(N_SW), channel of event.
- ev_type, output, 2, event type: 00 press, 01 release, 10 long press.
- ev_drop, output, 1, one-cycle pulse when an event is lost.

Function
REQ-003 Each sw bit SHALL pass a 2-flop synchronizer before any use.
REQ-004 One shared prescaler SHALL count 0..TICK_DIV-1 and wrap; tick is a one-cycle pulse at count TICK_DIV-1.
REQ-005 Each channel SHALL run the FSM LOW, WAIT_HI, HIGH, WAIT_LO with a 4-bit stable counter cnt.
REQ-006 LOW SHALL go to WAIT_HI with cnt=0 when the synced input is 1; HIGH SHALL go to WAIT_LO with cnt=0 when it is 0.
REQ-007 In WAIT_HI/WAIT_LO, a synced input back at the old level SHALL return to LOW/HIGH immediately, with no event.
REQ-008 In WAIT_HI/WAIT_LO, each tick SHALL increment cnt; on the tick where cnt==DB_TICKS-1 the FSM SHALL enter HIGH/LOW.
REQ-009 db SHALL update on the cycle after that tick, and the same cycle SHALL set the channel pending slot to press/release.
REQ-010 Each channel SHALL hold one pending slot; a new event into a full slot SHALL be discarded with ev_drop pulsed for one cycle.
REQ-011 Arbitration SHALL be round-robin starting at the channel after the last granted one.
REQ-012 The output register SHALL load the granted event one cycle after the slot is set, clear that slot the same cycle, and raise ev_valid.
REQ-013 ev_valid, ev_id and ev_type SHALL hold stable until the cycle where ev_valid and ev_ready are both 1.
REQ-014 In the cycle after the accepting cycle, a new grant MAY load, giving one event per 2 cycles.
REQ-015 A slot set in the same cycle as a grant of another channel SHALL be kept, not lost.
REQ-016 Prescaler wrap and FSM transitions SHALL be independent of the event handshake; ev_ready stalls never block debouncing.

Reset
REQ-017 rst SHALL set, synchronously:
- db=0, ev_valid=0, ev_id=0, ev_type=00, ev_drop=0.
- prescaler=0, all FSMs to LOW, all cnt=0, all slots empty, round-robin pointer=0, synchronizers=0.
REQ-018 rst asserted mid-debounce or mid-handshake SHALL discard all in-flight state with no event emitted.

Configuration
REQ-019 With BTN_LONG_PRESS_EN defined:
- each channel SHALL count ticks in HIGH, saturating at LONG_TICKS.
- it SHALL queue exactly one long-press event (type 10) per press when the count reaches LONG_TICKS.
- the count SHALL reset on leaving HIGH.
REQ-020 Without BTN_LONG_PRESS_EN, no long-press counter SHALL exist and type 10 SHALL never be emitted.

Structure
REQ-021 Package btn_pkg SHALL hold:
- the channel state enum (LOW, WAIT_HI, HIGH, WAIT_LO).
- the ev_type enum (PRESS=00, RELEASE=01, LONG=10).
- the counter width constant (4).
REQ-022 Per-channel synchronizer, FSM and long-press counter SHALL be sub-module btn_db_ch, instantiated N_SW times; prescaler, slots and arbiter live in btn_event_ctrl.

Verification (TICK_DIV=4, DB_TICKS=3, LONG_TICKS=5, N_SW=4)
REQ-023 sw[0] 0->1 held, ev_ready=1 -> db[0]=1 after 3 ticks; ev_valid next cycle with ev_id=0, ev_type=00.
REQ-024 sw[1] high for only 2 ticks, then low -> db[1] stays 0; no event.
REQ-025 sw[0..3] all settle high on the same tick, ev_ready=1 -> four press events with ev_id 0,1,2,3 in order, one every 2 cycles.
REQ-026 ev_ready=0 with sw[2] pressed then released -> press held on output; release waits in slot; next channel-2 event pulses ev_drop.
REQ-027 rst pulsed while sw[3] is in WAIT_HI -> all outputs 0 the next cycle; no event.
REQ-028 With BTN_LONG_PRESS_EN, sw[0] held 10 ticks -> press, then exactly one ev_type=10 event after 5 further ticks.
